// File: rtl/logic_or_pkg.sv
// ---------------------------------------------------------------------------
// logic_or_pkg
//
// Purpose:
//   Shared constants and helpers for the logic_or_gate block: default
//   parameter values for the OR primitive and the saturating increment
//   used by its activity monitor.
//
// Contents:
//   LOGIC_OR_WIDTH_DEF  default operand/result width
//   LOGIC_OR_CNT_W_DEF  default hit counter width
//   SAT_INC_W           working width of sat_inc (counters up to 64 bits)
//   sat_inc()           increment that sticks at a caller-supplied maximum
// ---------------------------------------------------------------------------
package logic_or_pkg;

    localparam int LOGIC_OR_WIDTH_DEF = 1;
    localparam int LOGIC_OR_CNT_W_DEF = 8;

    // sat_inc works on a fixed 64-bit container so a single function serves
    // every counter width; callers zero-extend in and truncate the result.
    localparam int SAT_INC_W = 64;

    // Returns value+1, or maxValue once value has reached it, so a counter
    // driven through this function never wraps.
    function automatic logic [SAT_INC_W-1:0] sat_inc(
        input logic [SAT_INC_W-1:0] value,
        input logic [SAT_INC_W-1:0] maxValue
    );
        if (value >= maxValue) begin
            return maxValue;
        end
        return value + {{(SAT_INC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/logic_or_stats.sv
// ---------------------------------------------------------------------------
// logic_or_stats
//
// Purpose:
//   Activity monitor for logic_or_gate. Counts enabled cycles in which the
//   merged OR result is non-zero (saturating) and keeps a sticky flag that
//   records whether any such cycle has happened since the last clear/reset.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   qualifies counting and flag setting
//   clr      in   synchronous clear of count and flag, wins over en/hit
//   hit      in   reduction-OR of the merged result for this cycle
//   hit_cnt  out  saturating count of enabled hit cycles
//   seen     out  sticky "a hit has occurred" flag
//
// CNT_W must lie in 1..64 (limited by the width of sat_inc).
// ---------------------------------------------------------------------------
module logic_or_stats
    import logic_or_pkg::*;
#(
    parameter int CNT_W = LOGIC_OR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             seen
);

    // All-ones value of a CNT_W-bit counter, expressed in sat_inc's width.
    // For CNT_W=64 the shift yields zero and the subtraction wraps to all ones.
    localparam logic [SAT_INC_W-1:0] CNT_MAX =
        (64'd1 << CNT_W) - 64'd1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             seen_q;
    logic             seen_d;

    // Next-state selection: clear dominates, then an enabled hit bumps the
    // counter (saturating) and arms the sticky flag; otherwise hold.
    always_comb begin
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (clr) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (en && hit) begin
            cnt_d  = CNT_W'(sat_inc(SAT_INC_W'(cnt_q), CNT_MAX));
            seen_d = 1'b1;
        end
    end

    // State registers; reset empties the monitor without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign hit_cnt = cnt_q;
    assign seen    = seen_q;

endmodule

// File: rtl/logic_or_gate.sv
// ---------------------------------------------------------------------------
// logic_or_gate
//
// Purpose:
//   Bitwise two-operand OR used to merge flag/mask vectors. Provides the
//   result combinationally, a one-cycle registered copy, and an activity
//   monitor (hit counter + sticky flag) for control logic.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (deassertion synchronised
//                 outside this block)
//   a, b     in   WIDTH-bit operands
//   en       in   enables updates of y_q, hit_cnt and seen
//   clr      in   synchronous clear of hit_cnt and seen
//   y        out  a | b, purely combinational
//   y_q      out  y captured on enabled rising edges
//   hit_cnt  out  saturating count of enabled cycles with y non-zero
//   seen     out  sticky flag, set by any enabled cycle with y non-zero
// ---------------------------------------------------------------------------
module logic_or_gate
    import logic_or_pkg::*;
#(
    parameter int WIDTH = LOGIC_OR_WIDTH_DEF,
    parameter int CNT_W = LOGIC_OR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             seen
);

    logic [WIDTH-1:0] yReg_q;
    logic [WIDTH-1:0] yReg_d;
    logic             hit;

    // The merged result is left completely unqualified: it ignores clock,
    // reset, enable and clear, and passes X/Z through as the OR operator does.
    assign y   = a | b;
    assign hit = |y;

    // Registered copy only tracks the result on enabled edges; clr does not
    // touch it.
    always_comb begin
        yReg_d = yReg_q;
        if (en) begin
            yReg_d = y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yReg_q <= '0;
        end else begin
            yReg_q <= yReg_d;
        end
    end

    assign y_q = yReg_q;

    logic_or_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .hit     (hit),
        .hit_cnt (hit_cnt),
        .seen    (seen)
    );

endmodule

// File: tb/tb_logic_or_gate.sv
// ---------------------------------------------------------------------------
// tb_logic_or_gate
//
// Directed bench for logic_or_gate. Two instances share clock and reset:
//   uNarrow  WIDTH=1, CNT_W=8  (combinational sweep, registered path, reset)
//   uWide    WIDTH=8, CNT_W=2  (wide vectors, saturation, clear priority)
// Inputs change on falling edges or mid-cycle; outputs are sampled 1 ns
// after the event under test, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_logic_or_gate;

    logic       clk;
    logic       rst_n;

    logic       aN;
    logic       bN;
    logic       enN;
    logic       clrN;
    logic       yN;
    logic       yqN;
    logic [7:0] cntN;
    logic       seenN;

    logic [7:0] aW;
    logic [7:0] bW;
    logic       enW;
    logic       clrW;
    logic [7:0] yW;
    logic [7:0] yqW;
    logic [1:0] cntW;
    logic       seenW;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Operand table shared by the combinational sweep and the registered path.
    logic [1:0] vecAB  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    logic       vecY   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    logic_or_gate #(
        .WIDTH (1),
        .CNT_W (8)
    ) uNarrow (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (aN),
        .b       (bN),
        .en      (enN),
        .clr     (clrN),
        .y       (yN),
        .y_q     (yqN),
        .hit_cnt (cntN),
        .seen    (seenN)
    );

    logic_or_gate #(
        .WIDTH (8),
        .CNT_W (2)
    ) uWide (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (aW),
        .b       (bW),
        .en      (enW),
        .clr     (clrW),
        .y       (yW),
        .y_q     (yqW),
        .hit_cnt (cntW),
        .seen    (seenW)
    );

    // 20 ns clock period, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Drives the narrow instance's inputs in one step.
    task automatic applyStimulus(input logic a, input logic b,
                                 input logic en, input logic clr);
        aN   = a;
        bN   = b;
        enN  = en;
        clrN = clr;
    endtask

    // One comparison: counts it, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        aW   = 8'h00;
        bW   = 8'h00;
        enW  = 1'b0;
        clrW = 1'b0;

        // Reset state.
        #5;
        checkOutput("reset_yq_n",    32'(yqN),   32'h0);
        checkOutput("reset_cnt_n",   32'(cntN),  32'h0);
        checkOutput("reset_seen_n",  32'(seenN), 32'h0);
        checkOutput("reset_yq_w",    32'(yqW),   32'h0);
        checkOutput("reset_cnt_w",   32'(cntW),  32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Combinational sweep, en=0, operands change every 10 ns mid-cycle.
        #5;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecAB[i][1], vecAB[i][0], 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("comb_y_%0d", i), 32'(yN), 32'(vecY[i]));
            #9;
        end
        checkOutput("comb_yq_hold",   32'(yqN),   32'h0);
        checkOutput("comb_cnt_hold",  32'(cntN),  32'h0);
        checkOutput("comb_seen_hold", 32'(seenN), 32'h0);

        // Registered path, en=1, one vector per clock.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(vecAB[i][1], vecAB[i][0], 1'b1, 1'b0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("reg_yq_%0d", i), 32'(yqN), 32'(vecY[i]));
        end
        checkOutput("reg_cnt_after6", 32'(cntN),  32'd4);
        checkOutput("reg_seen_after6", 32'(seenN), 32'h1);

        // Hold: en=0 with a zero result must leave y_q and the count alone.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("hold_yq",  32'(yqN),  32'h1);
        checkOutput("hold_cnt", 32'(cntN), 32'd4);

        // Wide vectors.
        @(negedge clk);
        aW = 8'hA5;
        bW = 8'h0F;
        #1;
        checkOutput("wide_y_af", 32'(yW), 32'hAF);
        aW  = 8'h00;
        bW  = 8'h00;
        enW = 1'b1;
        #1;
        checkOutput("wide_y_00", 32'(yW), 32'h00);
        @(posedge clk);
        #1;
        checkOutput("wide_zero_cnt",  32'(cntW),  32'h0);
        checkOutput("wide_zero_seen", 32'(seenW), 32'h0);

        // Saturation with a 2-bit counter: 1,2,3,3,3.
        @(negedge clk);
        aW = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat_cnt_%0d", i), 32'(cntW),
                        (i < 3) ? 32'(i + 1) : 32'd3);
            checkOutput($sformatf("sat_seen_%0d", i), 32'(seenW), 32'h1);
        end

        // Clear wins over an enabled hit; y_q still follows en.
        @(negedge clk);
        clrW = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clr_cnt",  32'(cntW),  32'h0);
        checkOutput("clr_seen", 32'(seenW), 32'h0);
        checkOutput("clr_yq",   32'(yqW),   32'h01);
        @(negedge clk);
        clrW = 1'b0;
        enW  = 1'b0;

        // Bring the narrow monitor to hit_cnt=2, y_q=1.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_clr_cnt", 32'(cntN), 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_cnt", 32'(cntN), 32'd2);
        checkOutput("pre_rst_yq",  32'(yqN),  32'h1);

        // Async reset dropped mid-cycle: clears without an edge.
        #4;
        rst_n = 1'b0;
        #1;
        checkOutput("async_yq",   32'(yqN),   32'h0);
        checkOutput("async_cnt",  32'(cntN),  32'h0);
        checkOutput("async_seen", 32'(seenN), 32'h0);
        checkOutput("async_yq_w", 32'(yqW),   32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("async_y_live", 32'(yN), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("rst_held_cnt", 32'(cntN), 32'h0);

        // First edge after release operates normally.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_cnt",  32'(cntN),  32'd1);
        checkOutput("post_rst_yq",   32'(yqN),   32'h1);
        checkOutput("post_rst_seen", 32'(seenN), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: observed no completion, expected finish before 20000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/logic_or_gate.md
# logic_or_gate

Bitwise two-operand OR primitive with a zero-latency combinational output, a one-cycle registered copy, and a small activity monitor. It sits in the datapath wherever two flag or mask vectors are merged. The monitor counts cycles in which the merged result is non-zero, so control logic can observe activity without extra glue.

## Interface
Parameters:
- WIDTH, 1, operand and result width in bits (≥1).
- CNT_W, 8, width of the hit counter (≥1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- en  in  1  enables `y_q`, `hit_cnt` and `seen` updates.
- clr  in  1  synchronous clear of `hit_cnt` and `seen`.
- y  out  WIDTH  combinational result, `a | b`.
- y_q  out  WIDTH  registered result.
- hit_cnt  out  CNT_W  saturating count of enabled cycles with `|y == 1`.
- seen  out  1  sticky flag; set once any enabled cycle has `|y == 1`.

## Operation
- `y = a | b`, bitwise, purely combinational. It is independent of `clk`, `rst_n`, `en` and `clr`.
- Truth per bit: 0|0=0, 0|1=1, 1|0=1, 1|1=1.
- `y` propagates X/Z the same way the OR operator does. Nothing is masked or forced.
- `y_q` loads `y` on each rising edge where `en=1`. It holds its value when `en=0`.
- `hit_cnt` increments by 1 on an edge where `en=1` and `|y=1`. It saturates at 2^CNT_W−1 and never wraps.
- `seen` is set on an edge where `en=1` and `|y=1`. It stays set until `clr` or reset.
- `clr=1` takes priority over increment and set:
  - `hit_cnt` and `seen` go to 0 on that edge.
  - `y_q` still follows the `en` rule.
- Reset (`rst_n=0`) drives `y_q`, `hit_cnt` and `seen` to 0 immediately, regardless of `clk`.
- While `rst_n=0`, `y` keeps reflecting `a | b`.
- Reset asserted mid-operation discards all accumulated state. There is no partial update.

## Timing
- `y`: zero-cycle latency. It settles within the same simulation timestep as an `a`/`b` change, including mid-cycle changes.
- `y_q`, `hit_cnt`, `seen`: one-cycle latency. They reflect the values present at the rising edge.
- Operand changes between edges affect only `y`. Registered outputs sample whatever is present at the edge.
- `hit_cnt`, `y_q` and `seen` all change on the same edge. No output depends on another output's registered value.
- First edge after `rst_n` deasserts: normal operation. No dead cycle.

## Structure
- Package `logic_or_pkg`:
  - default constants `LOGIC_OR_WIDTH_DEF = 1` and `LOGIC_OR_CNT_W_DEF = 8`;
  - function `sat_inc` for the saturating increment.
- Top `logic_or_gate` holds the combinational OR and the `y_q` register.
- One sub-module, `logic_or_stats`, holds `hit_cnt` and `seen`, including the clr/saturation/reset logic. Its inputs are `clk`, `rst_n`, `en`, `clr` and `hit = |y`.

## Test plan
- Combinational sweep, WIDTH=1, `en=0`, `a`/`b` changed every 10 ns (half of the 20 ns clock period), with sequence (0,0),(0,1),(1,0),(1,1),(0,0),(1,1):
  - `y` = 0,1,1,1,0,1 in the same timestep as each change;
  - `y_q`, `hit_cnt` and `seen` stay 0.
- Registered path, `en=1`, same sequence applied once per clock:
  - `y_q` lags `y` by exactly one edge;
  - after 6 edges, `hit_cnt=4` and `seen=1`.
- Saturation, CNT_W=2, `a=1`, `en=1` for 5 edges:
  - `hit_cnt` = 1,2,3,3,3, with no wrap;
  - `seen=1` from the first edge.
- Clear priority: `hit_cnt=3`, `seen=1`, then `clr=1` with `en=1` and `a=1` for one edge:
  - next `hit_cnt=0`, `seen=0`, `y_q=1`.
- Async reset mid-cycle, `hit_cnt=2`, `y_q=1`, with `rst_n` dropped between edges:
  - `y_q`, `hit_cnt` and `seen` go to 0 immediately, without waiting for an edge;
  - `y` still equals `a|b`.
- Wide vector, WIDTH=8, `a=8'hA5`, `b=8'h0F`: `y=8'hAF`; with `a=b=8'h00`: `y=8'h00` and `hit_cnt` is not incremented.
